// File: rtl/n1_pkg.sv
// ============================================================================
// Module   : n1_pkg
// Desc     : Shared n1 types and constants: loader states, RAM geometry, opcodes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package n1_pkg;

  localparam int N1_RAM_SIZE = 128;
  localparam int N1_WORD_W   = 16;

  typedef enum logic [2:0] {
    COUNT = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    RUN   = 3'd5,
    ERR   = 3'd6
  } ld_state_t;

  // Top three bits of an n1 instruction word select the major opcode class
  localparam logic [2:0] N1_OP_JMP  = 3'b000;
  localparam logic [2:0] N1_OP_JZ   = 3'b001;
  localparam logic [2:0] N1_OP_CALL = 3'b010;
  localparam logic [2:0] N1_OP_ALU  = 3'b011;
  localparam logic [0:0] N1_OP_LIT  = 1'b1;

  function automatic logic ld_state_ready(input ld_state_t s);
    return (s == COUNT) || (s == HI) || (s == LO) || (s == CHK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/n1_program_loader.sv
// ============================================================================
// Module   : n1_program_loader
// Desc     : Streams a framed byte image into n1 CPU RAM while holding the CPU
//            in reset. Optional trailing checksum: N1_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module n1_program_loader
  import n1_pkg::*;
#(
  parameter  int RAM_SIZE  = N1_RAM_SIZE,
  localparam int ADDR_BITS = $clog2(RAM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  start,
  output logic [ADDR_BITS-1:0]  ld_addr,
  output logic [N1_WORD_W-1:0]  ld_data,
  output logic                  ld_we,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  ld_state_t              state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [ADDR_BITS-1:0]   last_q, last_d;
  logic [N1_WORD_W-1:0]   data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   we_q, we_d;
  logic                   hold_q, hold_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   xfer;

`ifdef N1_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] chk_total;
  assign chk_total = sum_q + in_data;
`endif

  assign xfer = in_valid && ready_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    data_d  = data_q;
`ifdef N1_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      COUNT: begin
        if (xfer) begin
          if (in_data == 8'd0 || int'(in_data) > RAM_SIZE) begin
            state_d = ERR;
          end else begin
            // Count is range-checked, so N-1 always fits the address width
            last_d  = ADDR_BITS'(in_data - 8'd1);
            addr_d  = '0;
            state_d = HI;
          end
        end
      end
      HI: begin
        if (xfer) begin
          data_d[15:8] = in_data;
`ifdef N1_LOADER_CHECKSUM_EN
          sum_d        = sum_q + in_data;
`endif
          state_d      = LO;
        end
      end
      LO: begin
        if (xfer) begin
          data_d[7:0] = in_data;
`ifdef N1_LOADER_CHECKSUM_EN
          sum_d       = sum_q + in_data;
`endif
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (addr_q == last_q) begin
`ifdef N1_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = RUN;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = HI;
        end
      end
      CHK: begin
`ifdef N1_LOADER_CHECKSUM_EN
        if (xfer) begin
          state_d = (chk_total == 8'h00) ? RUN : ERR;
        end
`else
        state_d = ERR;
`endif
      end
      RUN: begin
        if (start) begin
          addr_d  = '0;
`ifdef N1_LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
          state_d = COUNT;
        end
      end
      ERR: begin
        if (start) begin
`ifdef N1_LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
          state_d = COUNT;
        end
      end
      default: state_d = ERR;
    endcase

    // Outputs are registered versions of the next-state decode
    ready_d = ld_state_ready(state_d);
    we_d    = (state_d == WRITE);
    hold_d  = (state_d != RUN);
    done_d  = (state_d == RUN);
    err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COUNT;
      addr_q  <= '0;
      last_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef N1_LOADER_CHECKSUM_EN
      sum_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef N1_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign in_ready = ready_q;
  assign ld_addr  = addr_q;
  assign ld_data  = data_q;
  assign ld_we    = we_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign error    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_n1_program_loader.sv
// ============================================================================
// Module   : tb_n1_program_loader
// Desc     : Directed scoreboard bench for n1_program_loader (both builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_n1_program_loader;

  localparam int AW = 7;

  logic          clk;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          start;
  logic [AW-1:0] ld_addr;
  logic [15:0]   ld_data;
  logic          ld_we;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int n_checks;
  int n_fail;
  int n_writes;

  int          exp_addr[$];
  logic [15:0] exp_data[$];
  logic [7:0]  frame[$];

  n1_program_loader #(.RAM_SIZE(128)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .start(start), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_we(ld_we), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued word
  always @(negedge clk) begin
    if (ld_we === 1'b1) begin
      n_writes++;
      if (exp_addr.size() == 0) begin
        chk("unexpected_write", {25'd0, ld_addr}, 32'hFFFF_FFFF);
      end else begin
        chk("wr_addr", {25'd0, ld_addr}, exp_addr.pop_front());
        chk("wr_data", {16'd0, ld_data}, {16'd0, exp_data.pop_front()});
      end
    end
    if (done === 1'b1 && error === 1'b1) chk("done_and_error", 32'd1, 32'd0);
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  // Sends frame[] (count + word bytes), queues expected writes, appends
  // checksum in the checksum build; gap inserts one idle cycle per byte.
  task automatic send_frame(input bit gap);
    logic [7:0] s;
    int nw;
    s  = 8'h00;
    nw = int'(frame[0]);
    for (int i = 0; i < nw; i++) begin
      exp_addr.push_back(i);
      exp_data.push_back({frame[1+2*i], frame[2+2*i]});
      s = s + frame[1+2*i] + frame[2+2*i];
    end
`ifdef N1_LOADER_CHECKSUM_EN
    frame.push_back(8'h00 - s);
`endif
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i]);
      if (gap && i != frame.size() - 1) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    frame.delete();
  endtask

  task automatic expect_run(input string tag, input int writes_before, input int nw);
    @(negedge clk);
    in_valid = 1'b0;
`ifndef N1_LOADER_CHECKSUM_EN
    chk({tag, "_last_we"}, {31'd0, ld_we}, 32'd1);
    @(negedge clk);
`endif
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_nwrites"}, n_writes - writes_before, nw);
    chk({tag, "_sb_empty"}, exp_addr.size(), 32'd0);
  endtask

  task automatic expect_err(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_error"}, {31'd0, error}, 32'd1);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_we"},    {31'd0, ld_we}, 32'd0);
    chk({tag, "_addr"},  {25'd0, ld_addr}, 32'd0);
    chk({tag, "_data"},  {16'd0, ld_data}, 32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    int wb;
    n_checks = 0; n_fail = 0; n_writes = 0;
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Two-word frame, valid held high
    wb = n_writes;
    frame = '{8'h02, 8'h10, 8'h05, 8'h80, 8'h00};
    send_frame(1'b0);
    expect_run("two_words", wb, 2);

    // Zero count
    pulse_start();
    chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
    chk("restart_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h00);
    expect_err("count_zero");
    pulse_start();
    chk("err_clear_ready", {31'd0, in_ready}, 32'd1);
    chk("err_clear_error", {31'd0, error}, 32'd0);

    // Count just above RAM size
    send_byte(8'h81);
    expect_err("count_over");
    pulse_start();
    chk("err2_clear_ready", {31'd0, in_ready}, 32'd1);
    chk("err2_clear_error", {31'd0, error}, 32'd0);

    // Toggling valid
    wb = n_writes;
    frame = '{8'h01, 8'h10, 8'h05};
    send_frame(1'b1);
    expect_run("toggle", wb, 1);

    // Reset while in LO
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h10);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    exp_addr.delete(); exp_data.delete();
    @(negedge clk);
    rst = 1'b0;
    wb = n_writes;
    frame = '{8'h01, 8'hA0, 8'h03};
    send_frame(1'b0);
    expect_run("after_reset", wb, 1);

    // Restart from RUN: hold reasserts on the sampling edge
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("run_start_hold", {31'd0, cpu_hold}, 32'd1);
    chk("run_start_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    wb = n_writes;
    frame = '{8'h01, 8'hE0, 8'h00};
    send_frame(1'b0);
    expect_run("reload", wb, 1);

    // start ignored mid-load
    pulse_start();
    send_byte(8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_ready", {31'd0, in_ready}, 32'd1);
    chk("start_ignored_hold", {31'd0, cpu_hold}, 32'd1);
    wb = n_writes;
    exp_addr.push_back(0);
    exp_data.push_back(16'h1234);
    send_byte(8'h12);
    send_byte(8'h34);
`ifdef N1_LOADER_CHECKSUM_EN
    send_byte(8'h00 - 8'h12 - 8'h34);
`endif
    expect_run("start_ignored", wb, 1);

`ifdef N1_LOADER_CHECKSUM_EN
    // Explicit checksum frames
    pulse_start();
    wb = n_writes;
    exp_addr.push_back(0);
    exp_data.push_back(16'h1005);
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h05); send_byte(8'hEB);
    expect_run("cksum_good", wb, 1);
    pulse_start();
    exp_addr.push_back(0);
    exp_data.push_back(16'h1005);
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h05); send_byte(8'hEC);
    expect_err("cksum_bad");
`endif

    repeat (3) @(negedge clk);
    chk("final_sb_empty", exp_addr.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
